// File: rtl/tone_sequencer.sv
// Programmable STEPS-entry buzzer melody player: one table divisor per tempo step on bz1.
// Optional build macro NOTE_GAP_EN silences the last TICKS/8 clocks of every step.
module tone_sequencer #(
  parameter int CLK_HZ   = 50000000,
  parameter int TEMPO_HZ = 4,
  parameter int STEPS    = 8,
  parameter int DIV_W    = 27,
  localparam int AW      = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             bz1,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step_idx
);

  localparam int TICKS = CLK_HZ / TEMPO_HZ;
  localparam int TW    = $clog2(TICKS);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state;
  logic [DIV_W-1:0] tbl [STEPS];
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] tone_cnt;
  logic [TW-1:0]    tempo_cnt;
  logic             last_step;
  logic             step_end;
  logic             tone_hit;
  logic [AW-1:0]    next_idx;

  assign last_step = (step_idx == AW'(STEPS - 1));
  assign step_end  = (tempo_cnt == TW'(TICKS - 1));
  assign tone_hit  = (div_q != '0) && (tone_cnt == div_q - DIV_W'(1));
  assign next_idx  = last_step ? '0 : step_idx + AW'(1);

`ifdef NOTE_GAP_EN
  // Gap covers the final TICKS/8 cycles, so silence is scheduled one edge early.
  logic in_gap;
  assign in_gap = (tempo_cnt >= TW'(TICKS - TICKS / 8 - 1));
`endif

  // NOTE: the table must read back as zero after reset, so it is built from
  // resettable flops rather than an inferred RAM (which cannot be reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_div;
    end
  end

  // NOTE: every register here uses non-blocking assignment, so a table write and
  // a step load on the same edge see the old table value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bz1       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
      div_q     <= '0;
      tone_cnt  <= '0;
      tempo_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          bz1 <= 1'b0;
          if (start && !stop) begin
            state     <= PLAY;
            busy      <= 1'b1;
            step_idx  <= '0;
            div_q     <= tbl[0];
            tone_cnt  <= '0;
            tempo_cnt <= '0;
          end
        end
        PLAY: begin
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bz1      <= 1'b0;
            step_idx <= '0;
          end else if (step_end) begin
            tempo_cnt <= '0;
            tone_cnt  <= '0;
            bz1       <= 1'b0;
            if (last_step && !loop) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              step_idx <= '0;
            end else begin
              step_idx <= next_idx;
              div_q    <= tbl[next_idx];
            end
`ifdef NOTE_GAP_EN
          end else if (in_gap) begin
            tempo_cnt <= tempo_cnt + TW'(1);
            tone_cnt  <= '0;
            bz1       <= 1'b0;
`endif
          end else begin
            tempo_cnt <= tempo_cnt + TW'(1);
            if (tone_hit) begin
              bz1      <= ~bz1;
              tone_cnt <= '0;
            end else begin
              tone_cnt <= tone_cnt + DIV_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
